uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_arb.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: two-port byte arbiter feeding a single uart_tx.
// Accepts one byte at a time. Each byte is presented on tx_data with a
// one-cycle tx_en start pulse. The arbiter then stays busy for one full
// 10-bit frame plus a guard gap before it accepts the next byte.
// Optional feature macro: UART_TX_ARB_RR_EN selects round-robin arbitration
// on ties. When it is undefined, port 0 has fixed priority.
module uart_tx_arb #(
  parameter int unsigned BAUD_CNT_MAX = 5207,
  parameter int unsigned GUARD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0_valid,
  input  logic       req1_valid,
  input  logic [7:0] req0_data,
  input  logic [7:0] req1_data,
  output logic       req0_ready,
  output logic       req1_ready,
  output logic [7:0] tx_data,
  output logic       tx_en,
  output logic       busy,
  output logic       grant_id
);

  // One frame is 10 bit times plus the idle guard gap, counted in clocks.
  localparam int unsigned FRAME_CYCLES = 10 * BAUD_CNT_MAX + GUARD_CYCLES;
  localparam logic [16:0] FRAME_LAST   = 17'(FRAME_CYCLES - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [16:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  tx_data_q;
  logic        tx_en_q;
  logic        busy_q;
  logic        grant_q;
  logic        winner_s;
  logic        accept_s;

  // A byte is taken whenever we are idle and anybody is offering one.
  assign accept_s = (state_q == ST_IDLE) && (req0_valid || req1_valid);

`ifdef UART_TX_ARB_RR_EN
  logic last_grant_q;

  // Remember the most recent winner so that contested cycles alternate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
    end else if (accept_s) begin
      last_grant_q <= winner_s;
    end else begin
      last_grant_q <= last_grant_q;
    end
  end

  // Round-robin pick: on a tie the port that did not win last time goes.
  always_comb begin
    winner_s = 1'b0;
    if (req0_valid && req1_valid) begin
      winner_s = ~last_grant_q;
    end else if (req1_valid) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
  end
`else
  // Fixed priority pick: port 0 wins whenever it is valid.
  always_comb begin
    winner_s = 1'b0;
    if (req0_valid) begin
      winner_s = 1'b0;
    end else if (req1_valid) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
  end
`endif

  // FSM state and frame timer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      frame_cnt_q <= 17'd0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Next-state logic. WAIT runs exactly FRAME_CYCLES clocks.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = 17'd0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        frame_cnt_d = frame_cnt_q + 17'd1;
        if (frame_cnt_q == FRAME_LAST) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Ready outputs. These go only to the winner, and only while idle.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req0_ready = req0_valid & ~winner_s;
        req1_ready = req1_valid & winner_s;
      end
      default: begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
      end
    endcase
  end

  // Capture the accepted byte and winner, and register tx_en and busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_data_q <= 8'h00;
      grant_q   <= 1'b0;
      tx_en_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      tx_en_q <= accept_s;
      busy_q  <= (state_d != ST_IDLE);
      if (accept_s) begin
        tx_data_q <= winner_s ? req1_data : req0_data;
        grant_q   <= winner_s;
      end else begin
        tx_data_q <= tx_data_q;
        grant_q   <= grant_q;
      end
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_en    = tx_en_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: scenario tasks plus a behavioural arbitration/timing model.
// The frame is 10*56+16 = 576 clocks, and starts are spaced 578 clocks apart.
module tb_uart_tx_arb;

  localparam int BAUD  = 56;
  localparam int GUARD = 16;
  localparam int FRAME = 10 * BAUD + GUARD;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic [7:0] tx_data;
  logic       tx_en, busy, grant_id;

  int    n_vec = 0;
  int    n_err = 0;
  longint cyc = 0;
  bit    model_last = 1'b1;

  typedef struct {
    longint     t;
    logic [7:0] d;
    logic       g;
  } pulse_t;
  pulse_t     pulses[$];
  int         stab_viol = 0;
  logic [7:0] prev_data = 8'h00;

  uart_tx_arb #(.BAUD_CNT_MAX(BAUD), .GUARD_CYCLES(GUARD)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .tx_data(tx_data), .tx_en(tx_en), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every start pulse, and flag any tx_data change that has no start pulse.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_data <= tx_data;
    end else begin
      if (tx_en === 1'b1) pulses.push_back('{t: cyc, d: tx_data, g: grant_id});
      else if (tx_data !== prev_data) stab_viol <= stab_viol + 1;
      prev_data <= tx_data;
    end
  end

  // Reference arbitration rule.
  function automatic bit model_pick(bit v0, bit v1);
`ifdef UART_TX_ARB_RR_EN
    if (v0 && v1) return !model_last;
`else
    if (v0 && v1) return 1'b0;
`endif
    return v0 ? 1'b0 : 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_last = 1'b1;
    tick();
  endtask

  task automatic hold_until_accept(input bit port, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      #1;
      if ((port ? req1_ready : req0_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) tick();
  endtask

  task automatic wait_idle(output int bcyc);
    bcyc = 0;
    for (int i = 0; i < 3000 && busy === 1'b1; i++) begin
      bcyc++;
      tick();
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_timeout: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset();
    int hits;
    reset_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = 8'h00; req1_data = 8'h00;
    #1 reset_n = 1'b0;
    #1;
    n_vec++; if (tx_en !== 1'b0) begin n_err++; $display("FAIL rst_tx_en: got %b want 0", tx_en); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
    n_vec++; if (grant_id !== 1'b0) begin n_err++; $display("FAIL rst_grant: got %b want 0", grant_id); end
    n_vec++; if ({req0_ready, req1_ready} !== 2'b00) begin n_err++; $display("FAIL rst_ready: got %b want 00", {req0_ready, req1_ready}); end
    do_reset();
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx_en !== 1'b0 || busy !== 1'b0) hits++;
      tick();
    end
    n_vec++; if (hits != 0) begin n_err++; $display("FAIL idle_quiet: %0d active cycles, want 0", hits); end
  endtask

  task automatic test_single();
    int bcyc, en_extra;
    logic [9:0] exp_f, obs_f;
    exp_f = {1'b1, 8'hA5, 1'b0};
    req0_valid = 1'b1; req0_data = 8'hA5;
    #1;
    n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL single_ready0: got %b want 1", req0_ready); end
    n_vec++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL single_ready1: got %b want 0", req1_ready); end
    tick();
    req0_valid = 1'b0; model_last = 1'b0;
    n_vec++; if (tx_en !== 1'b1) begin n_err++; $display("FAIL single_tx_en: got %b want 1", tx_en); end
    n_vec++; if (tx_data !== 8'hA5) begin n_err++; $display("FAIL single_tx_data: got %h want a5", tx_data); end
    n_vec++; if (grant_id !== 1'b0) begin n_err++; $display("FAIL single_grant: got %b want 0", grant_id); end
    bcyc = 0; en_extra = 0;
    for (int i = 0; i < 3000 && busy === 1'b1; i++) begin
      if (i > 0 && tx_en !== 1'b0) en_extra++;
      if (i % BAUD == BAUD / 2 && i / BAUD < 10) begin
        obs_f = {1'b1, tx_data, 1'b0};
        n_vec++;
        if (obs_f[i / BAUD] !== exp_f[i / BAUD]) begin
          n_err++; $display("FAIL single_line_bit%0d: got %b want %b", i / BAUD, obs_f[i / BAUD], exp_f[i / BAUD]);
        end
      end
      bcyc++;
      tick();
    end
    n_vec++; if (bcyc != FRAME + 1) begin n_err++; $display("FAIL single_busy_len: got %0d want %0d", bcyc, FRAME + 1); end
    n_vec++; if (en_extra != 0) begin n_err++; $display("FAIL single_tx_en_width: %0d extra cycles, want 0", en_extra); end
    n_vec++; if (tx_en !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL single_back_idle: tx_en=%b busy=%b want 0 0", tx_en, busy); end
  endtask

  task automatic test_spacing();
    bit ok;
    int bcyc, base;
    pulses.delete();
    base = stab_viol;
    for (int k = 0; k < 3; k++) begin
      req0_valid = 1'b1; req0_data = 8'(k + 1);
      hold_until_accept(1'b0, ok);
      model_last = 1'b0;
      n_vec++; if (!ok) begin n_err++; $display("FAIL spacing_accept%0d: not accepted, want accepted", k); end
    end
    req0_valid = 1'b0;
    wait_idle(bcyc);
    n_vec++; if (pulses.size() != 3) begin n_err++; $display("FAIL spacing_count: got %0d want 3", pulses.size()); end
    for (int k = 0; k < pulses.size() && k < 3; k++) begin
      n_vec++; if (pulses[k].d !== 8'(k + 1)) begin n_err++; $display("FAIL spacing_data%0d: got %h want %h", k, pulses[k].d, 8'(k + 1)); end
      if (k > 0) begin
        n_vec++;
        if (pulses[k].t - pulses[k-1].t != longint'(FRAME + 2)) begin
          n_err++; $display("FAIL spacing_gap%0d: got %0d want %0d", k, pulses[k].t - pulses[k-1].t, FRAME + 2);
        end
      end
    end
    n_vec++; if (stab_viol != base) begin n_err++; $display("FAIL spacing_stable: %0d changes, want 0", stab_viol - base); end
  endtask

  task automatic test_tie();
    int bcyc;
    bit w;
    bit exp_g[5];
    do_reset();
    pulses.delete();
    for (int i = 0; i < 4; i++) begin
      w = model_pick(1'b1, 1'b1); exp_g[i] = w; model_last = w;
    end
    w = model_pick(1'b0, 1'b1); exp_g[4] = w; model_last = w;
    req0_valid = 1'b1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_data = 8'h22;
    for (int i = 0; i < 3000 && pulses.size() < 4; i++) tick();
    req0_valid = 1'b0;
    for (int i = 0; i < 1000 && pulses.size() < 5; i++) tick();
    req1_valid = 1'b0;
    wait_idle(bcyc);
    n_vec++; if (pulses.size() != 5) begin n_err++; $display("FAIL tie_count: got %0d want 5", pulses.size()); end
    for (int i = 0; i < pulses.size() && i < 5; i++) begin
      n_vec++; if (pulses[i].g !== exp_g[i]) begin n_err++; $display("FAIL tie_grant%0d: got %b want %b", i, pulses[i].g, exp_g[i]); end
      n_vec++; if (pulses[i].d !== (exp_g[i] ? 8'h22 : 8'h11)) begin n_err++; $display("FAIL tie_data%0d: got %h want %h", i, pulses[i].d, exp_g[i] ? 8'h22 : 8'h11); end
      if (i > 0) begin
        n_vec++;
        if (pulses[i].t - pulses[i-1].t != longint'(FRAME + 2)) begin
          n_err++; $display("FAIL tie_gap%0d: got %0d want %0d", i, pulses[i].t - pulses[i-1].t, FRAME + 2);
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    int bcyc;
    req1_valid = 1'b1; req1_data = 8'h5A;
    hold_until_accept(1'b1, ok);
    req1_valid = 1'b0; model_last = 1'b1;
    n_vec++; if (!ok || grant_id !== 1'b1) begin n_err++; $display("FAIL rmw_pre_grant: ok=%b grant=%b want 1 1", ok, grant_id); end
    repeat (201) tick();
    reset_n = 1'b0;
    #1;
    n_vec++; if (tx_en !== 1'b0) begin n_err++; $display("FAIL rmw_tx_en: got %b want 0", tx_en); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmw_busy: got %b want 0", busy); end
    n_vec++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL rmw_tx_data: got %h want 00", tx_data); end
    n_vec++; if (grant_id !== 1'b0) begin n_err++; $display("FAIL rmw_grant: got %b want 0", grant_id); end
    req1_valid = 1'b1; req1_data = 8'h3C;
    @(negedge clk);
    reset_n = 1'b1; model_last = 1'b1;
    #1;
    n_vec++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL rmw_ready1: got %b want 1", req1_ready); end
    tick();
    req1_valid = 1'b0; model_last = 1'b1;
    n_vec++; if (tx_en !== 1'b1) begin n_err++; $display("FAIL rmw_tx_en_after: got %b want 1", tx_en); end
    n_vec++; if (tx_data !== 8'h3C) begin n_err++; $display("FAIL rmw_data_after: got %h want 3c", tx_data); end
    n_vec++; if (grant_id !== 1'b1) begin n_err++; $display("FAIL rmw_grant_after: got %b want 1", grant_id); end
    wait_idle(bcyc);
  endtask

  task automatic test_ignore();
    bit ok;
    int bcyc;
    req0_valid = 1'b1; req0_data = 8'h77;
    hold_until_accept(1'b0, ok);
    req0_valid = 1'b0; model_last = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 100; i++) begin
      req1_valid = 1'($urandom_range(0, 1)); req1_data = 8'($urandom);
      req0_valid = 1'($urandom_range(0, 1)); req0_data = 8'($urandom);
      #1;
      n_vec++; if ({req0_ready, req1_ready} !== 2'b00) begin n_err++; $display("FAIL ignore_ready%0d: got %b want 00", i, {req0_ready, req1_ready}); end
      n_vec++; if (tx_data !== 8'h77) begin n_err++; $display("FAIL ignore_data%0d: got %h want 77", i, tx_data); end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle(bcyc);
  endtask

  task automatic test_random();
    int bcyc;
    bit v0, v1, w;
    logic [1:0] v;
    logic [7:0] d0, d1;
    for (int it = 0; it < 8; it++) begin
      v = 2'($urandom_range(1, 3));
      v0 = v[0]; v1 = v[1];
      d0 = 8'($urandom); d1 = 8'($urandom);
      w = model_pick(v0, v1);
      req0_valid = v0; req0_data = d0;
      req1_valid = v1; req1_data = d1;
      #1;
      n_vec++;
      if ({req1_ready, req0_ready} !== (w ? 2'b10 : 2'b01)) begin
        n_err++; $display("FAIL rand_ready%0d: got %b want %b", it, {req1_ready, req0_ready}, w ? 2'b10 : 2'b01);
      end
      tick();
      model_last = w;
      req0_valid = 1'b0; req1_valid = 1'b0;
      n_vec++;
      if (tx_en !== 1'b1 || tx_data !== (w ? d1 : d0) || grant_id !== w) begin
        n_err++; $display("FAIL rand_start%0d: en=%b data=%h grant=%b want 1 %h %b", it, tx_en, tx_data, grant_id, w ? d1 : d0, w);
      end
      wait_idle(bcyc);
      n_vec++; if (bcyc != FRAME + 1) begin n_err++; $display("FAIL rand_busy%0d: got %0d want %0d", it, bcyc, FRAME + 1); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_spacing();
    test_tie();
    test_reset_mid_wait();
    test_ignore();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
